uart_mem_dump: RTL and testbench

Streams a window of the 1K×32 program SRAM out of `uart_tx_pin` as 8N1 UART bytes. It is the transmit-side counterpart of the UART loader and replaces the `dbg_sram` byte-probe walk with a host-visible dump. It drives the SRAM read port during the debug-transmit phase, before the core is released from reset. Each word is sent least-significant byte first, the same byte order the loader uses when writing.

---
 rtl/uart_mem_dump_if.sv | 26 ++
 rtl/uart_mem_dump.sv | 182 ++++++++++++++++++
 tb/tb_uart_mem_dump.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mem_dump_if.sv
// Port bundle between the SRAM dump engine (slave) and its host/SRAM/serial side (master).
interface uart_mem_dump_if #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   word_count;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              uart_tx_pin;
    logic              busy;
    logic              done;
    logic [7:0]        cur_byte;

    modport slave (
        input  start, start_addr, word_count, mem_rdata,
        output mem_rd_en, mem_addr, uart_tx_pin, busy, done, cur_byte
    );

    modport master (
        output start, start_addr, word_count, mem_rdata,
        input  mem_rd_en, mem_addr, uart_tx_pin, busy, done, cur_byte
    );
endinterface

// File: rtl/uart_mem_dump.sv
// Streams a window of the 1Kx32 program SRAM out as 8N1 UART bytes, least-significant byte first.
// Define UART_DUMP_HEADER_EN to prefix every non-empty dump with the loader sync byte 0x53.
module uart_mem_dump #(
    parameter int  CLKS_PER_BIT = 104,
    parameter int  DEPTH        = 1024,
    localparam int ADDR_W       = $clog2(DEPTH),
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT)
) (
    input  logic           clk,
    input  logic           RST,
    uart_mem_dump_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, LATCH, TX_START, TX_DATA, TX_STOP, DONE} state_t;

    localparam logic [7:0]        SYNC_BYTE   = 8'h53;
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        idx_q, idx_d;
    logic [2:0]        bit_q, bit_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic              zero_q, zero_d;
    logic              hdr_q, hdr_d;
    logic              bit_adv;
    logic              tick;

    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_q, rd_d;
    logic [7:0]        cur_q, cur_d;
    logic [7:0]        word_bytes [4];

    assign tick = (baud_q == '0);

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_bytes
        assign word_bytes[gi] = word_d[8*gi +: 8];
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        word_d   = word_q;
        idx_d    = idx_q;
        bit_d    = bit_q;
        zero_d   = zero_q;
        hdr_d    = hdr_q;
        bit_adv  = 1'b0;
        case (state_q)
            IDLE: begin
                zero_d = 1'b0;
                hdr_d  = 1'b0;
                if (bus.start) begin
                    addr_d   = bus.start_addr;
                    remain_d = bus.word_count;
                    if (bus.word_count == '0) begin
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end else begin
`ifdef UART_DUMP_HEADER_EN
                        hdr_d   = 1'b1;
                        idx_d   = 2'd0;
                        state_d = TX_START;
`else
                        state_d = READ;
`endif
                    end
                end
            end
            READ:  state_d = LATCH;
            LATCH: begin
                word_d  = bus.mem_rdata;
                idx_d   = 2'd0;
                state_d = TX_START;
            end
            TX_START: begin
                if (tick) begin
                    bit_d   = 3'd0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        bit_adv = 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        state_d = READ;
                    end else if (idx_q != 2'd3) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = TX_START;
                    end else if (remain_q > (ADDR_W+1)'(1)) begin
                        remain_d = remain_q - (ADDR_W+1)'(1);
                        // Explicit wrap keeps non-power-of-two depths inside the array.
                        addr_d   = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
                        state_d  = READ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight from a flop.
    always_comb begin
        cur_d = cur_q;
        if (state_d == TX_START) begin
            cur_d = hdr_d ? SYNC_BYTE : word_bytes[idx_d];
        end
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = cur_d[bit_d];
            default:  tx_d = 1'b1;
        endcase
        rd_d   = (state_d == READ);
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE) && !((state_d == DONE) && zero_d);
        baud_d = baud_q;
        if ((state_d != state_q) || bit_adv) begin
            baud_d = BAUD_RELOAD;
        end else if (!tick) begin
            baud_d = baud_q - BAUD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            word_q   <= '0;
            idx_q    <= '0;
            bit_q    <= '0;
            baud_q   <= '0;
            zero_q   <= 1'b0;
            hdr_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_q     <= 1'b0;
            cur_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            word_q   <= word_d;
            idx_q    <= idx_d;
            bit_q    <= bit_d;
            baud_q   <= baud_d;
            zero_q   <= zero_d;
            hdr_q    <= hdr_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_q     <= rd_d;
            cur_q    <= cur_d;
        end
    end

    assign bus.uart_tx_pin = tx_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.mem_rd_en   = rd_q;
    assign bus.mem_addr    = addr_q;
    assign bus.cur_byte    = cur_q;
endmodule

// File: tb/tb_uart_mem_dump.sv
// Bench for uart_mem_dump: SRAM model, UART decoder and byte/address scoreboards, table of dumps.
module tb_uart_mem_dump;
    localparam int CPB    = 4;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;
`ifdef UART_DUMP_HEADER_EN
    localparam int HDR = 10 * CPB;
`else
    localparam int HDR = 0;
`endif

    typedef struct {
        int addr;
        int n;
        int exp_done;
        int pulse_at;
    } vec_t;

    logic clk = 1'b0;
    logic RST = 1'b1;
    always #5 clk = ~clk;

    uart_mem_dump_if #(.DEPTH(DEPTH)) bus ();
    uart_mem_dump #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int t0 = 0;
    int first_start = -1;
    int first_rd = -1;
    int rd_cnt = 0;
    logic [7:0] exp_q [$];
    int         exp_addr_q [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    // UART decoder: samples each bit at its centre, resynchronises on every start edge
    initial begin : uart_mon
        int   cnt;
        int   k;
        bit   active;
        logic [7:0] sh;
        logic [7:0] e;
        active = 1'b0;
        cnt    = 0;
        sh     = '0;
        forever begin
            @(negedge clk);
            if (RST) begin
                active = 1'b0;
            end else if (!active) begin
                if (bus.uart_tx_pin == 1'b0) begin
                    active = 1'b1;
                    cnt    = 0;
                    if (first_start < 0) first_start = cyc - t0;
                end
            end else begin
                cnt++;
                if (cnt == CPB/2) begin
                    chk("start_bit", int'(bus.uart_tx_pin), 0);
                end else if (cnt > CPB/2 && ((cnt - CPB/2) % CPB) == 0) begin
                    k = (cnt - CPB/2) / CPB;
                    if (k <= 8) begin
                        sh[k-1] = bus.uart_tx_pin;
                    end else begin
                        active = 1'b0;
                        chk("stop_bit", int'(bus.uart_tx_pin), 1);
                        chk("cur_byte", int'(bus.cur_byte), int'(sh));
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL byte_unexpected actual %02h required none", sh);
                        end else begin
                            e = exp_q.pop_front();
                            $display("rx byte %02h expected %02h at cycle %0d", sh, e, cyc - t0);
                            chk("rx_byte", int'(sh), int'(e));
                        end
                    end
                end
            end
        end
    end

    initial begin : addr_mon
        forever begin
            @(negedge clk);
            if (!RST && bus.mem_rd_en === 1'b1) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc - t0;
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected actual addr %0d required none", bus.mem_addr);
                end else begin
                    chk("rd_addr", int'(bus.mem_addr), exp_addr_q.pop_front());
                end
            end
        end
    end

    task automatic push_expected(input int a, input int n);
        int w;
        if (HDR > 0 && n > 0) exp_q.push_back(8'h53);
        for (int i = 0; i < n; i++) begin
            w = (a + i) % DEPTH;
            exp_addr_q.push_back(w);
            for (int b = 0; b < 4; b++) exp_q.push_back(mem[w][8*b +: 8]);
        end
    endtask

    task automatic kick(input int a, input int n);
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.start_addr = ADDR_W'(a);
        bus.word_count = (ADDR_W+1)'(n);
        t0 = cyc;
        first_start = -1;
        first_rd    = -1;
        rd_cnt      = 0;
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
        bus.start_addr = ADDR_W'($urandom);
        bus.word_count = (ADDR_W+1)'($urandom);
    endtask

    task automatic run_dump(input vec_t v);
        int got;
        int busy_bad;
        int k;
        push_expected(v.addr, v.n);
        kick(v.addr, v.n);
        got = -1;
        busy_bad = 0;
        for (int c = 0; c < v.exp_done + 60 && got < 0; c++) begin
            @(negedge clk);
            k = cyc - t0;
            if (k == v.pulse_at) begin
                bus.start      = 1'b1;
                bus.start_addr = 10'd200;
                bus.word_count = 11'd3;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) got = k;
            else if ((v.n > 0) != (bus.busy === 1'b1)) busy_bad++;
        end
        bus.start = 1'b0;
        $display("dump addr %0d count %0d done at cycle %0d", v.addr, v.n, got);
        chk("done_cycle", got, v.exp_done);
        chk("busy_profile", busy_bad, 0);
        @(negedge clk);
        chk("after_done", int'({bus.done, bus.busy, bus.uart_tx_pin}), 1);
        chk("rd_count", rd_cnt, v.n);
        chk("first_rd", first_rd, (v.n > 0) ? 1 + HDR : -1);
        chk("first_start", first_start, (v.n > 0) ? ((HDR > 0) ? 1 : 3) : -1);
        chk("bytes_left", exp_q.size(), 0);
        chk("addrs_left", exp_addr_q.size(), 0);
    endtask

    vec_t vt [4];

    initial begin : main
        vt[0] = '{addr: 5,    n: 1, exp_done: 163 + HDR, pulse_at: -1};
        vt[1] = '{addr: 1022, n: 4, exp_done: 649 + HDR, pulse_at: -1};
        vt[2] = '{addr: 0,    n: 0, exp_done: 1,         pulse_at: -1};
        vt[3] = '{addr: 5,    n: 1, exp_done: 163 + HDR, pulse_at: 50};

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[5]   = 32'h44332211;
        mem[100] = 32'h12345600;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.word_count = '0;

        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs", int'({bus.uart_tx_pin, bus.busy, bus.done, bus.mem_rd_en}), 8);
        end
        chk("reset_addr_byte", int'({bus.mem_addr, bus.cur_byte}), 0);
        RST = 1'b0;

        for (int i = 0; i < 4; i++) run_dump(vt[i]);

        // Abort mid data bit: byte 0 of word 100 is all zeros, so the line is low there
        push_expected(100, 2);
        kick(100, 2);
        repeat (HDR + CPB + 4) @(negedge clk);
        chk("abort_pre_line", int'(bus.uart_tx_pin), 0);
        RST = 1'b1;
        #1;
        chk("abort_outputs", int'({bus.uart_tx_pin, bus.busy, bus.done, bus.mem_rd_en}), 8);
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(negedge clk);
        RST = 1'b0;

        run_dump(vt[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
